m_exc_unit: RTL and testbench

Memory-stage exception unit for the pipelined MIPS CPU. It is a parametrised successor to the fixed two-timer address checker. It classifies lw/lh/lhu/lb/lbu/sw/sh/sb accesses against the DM range and NUM_DEV device windows, and arbitrates against exceptions from earlier stages. It registers the result into the M/W boundary (ExcCode, BadVAddr) with stall/flush, and keeps saturating per-type fault counters for debug.

---
 rtl/m_exc_unit.sv | 85 ++++++++
 tb/tb_m_exc_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_exc_unit.sv
// m_exc_unit: memory-stage address exception classifier with M/W exception register and saturating fault counters
module m_exc_unit #(
  parameter int          NUM_DEV    = 2,
  parameter logic [31:0] DEV_BASE   = 32'h0000_7f00,
  parameter logic [31:0] DEV_STRIDE = 32'h10,
  parameter int          DEV_SIZE   = 12,
  parameter int          RO_OFFSET  = 8,
  parameter logic [31:0] DM_MAX     = 32'h0000_2fff,
  parameter int          CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      pc_i,
  input  logic [4:0]       exc_code_prev,
  input  logic             stall,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [4:0]       exc_code_m,
  output logic             mem_we_ok,
  output logic [4:0]       exc_code_w,
  output logic [31:0]      bad_vaddr_w,
  output logic [CNT_W-1:0] cnt_adel,
  output logic [CNT_W-1:0] cnt_ades
);
  logic [5:0] op;
  logic ld, st, sz_w, sz_h, misal, in_dm, dev_hit, ro_hit, fault, mem_sel, adv;
  logic [NUM_DEV-1:0] in_dev, ro;
  logic [CNT_W-1:0] adel_base, ades_base, adel_nxt, ades_nxt;
  logic unused_instr;
  assign op = instr[31:26];
  assign unused_instr = ^instr[25:0];
  assign ld = op inside {6'b100011, 6'b100001, 6'b100101, 6'b100000, 6'b100100};
  assign st = op inside {6'b101011, 6'b101001, 6'b101000};
  assign sz_w = op inside {6'b100011, 6'b101011};
  assign sz_h = op inside {6'b100001, 6'b100101, 6'b101001};
  genvar k;
  generate
    for (k = 0; k < NUM_DEV; k++) begin : g_dev
      localparam logic [31:0] BASE = DEV_BASE + 32'(k) * DEV_STRIDE;
      assign in_dev[k] = (mem_addr >= BASE) && ((mem_addr - BASE) < 32'(DEV_SIZE));
      assign ro[k] = mem_addr == BASE + 32'(RO_OFFSET);
    end
  endgenerate
  assign dev_hit = |in_dev;
  assign ro_hit = |ro;
  assign in_dm = mem_addr <= DM_MAX;
  assign misal = (sz_w & |mem_addr[1:0]) | (sz_h & mem_addr[0]);
  assign fault = (ld | st) & (misal | (~in_dm & ~dev_hit) | (dev_hit & ~sz_w) | (st & ro_hit));
  assign mem_sel = fault & (exc_code_prev == 5'd0);
  assign adv = ~flush & ~stall;
  assign exc_code_m = (exc_code_prev != 5'd0) ? exc_code_prev : fault ? (st ? 5'd5 : 5'd4) : 5'd0;
  assign mem_we_ok = st & (exc_code_m == 5'd0);
  // counter next values: clear first, then a saturating increment for an advancing selected fault
  always_comb begin
    adel_base = cnt_clr ? '0 : cnt_adel;
    ades_base = cnt_clr ? '0 : cnt_ades;
    adel_nxt = adel_base + CNT_W'(adv & mem_sel & ld & ~&adel_base);
    ades_nxt = ades_base + CNT_W'(adv & mem_sel & st & ~&ades_base);
  end
  // M/W exception register: flush squashes, stall holds, otherwise capture the selected cause
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_code_w <= '0;
      bad_vaddr_w <= '0;
    end else if (flush) begin
      exc_code_w <= '0;
      bad_vaddr_w <= '0;
    end else if (!stall) begin
      exc_code_w <= exc_code_m;
      bad_vaddr_w <= (exc_code_prev == 5'd4) ? pc_i : mem_sel ? mem_addr : '0;
    end
  end
  // debug fault counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_adel <= '0;
      cnt_ades <= '0;
    end else begin
      cnt_adel <= adel_nxt;
      cnt_ades <= ades_nxt;
    end
  end
endmodule

// File: tb/tb_m_exc_unit.sv
// tb_m_exc_unit: directed and randomized checks of m_exc_unit against a behavioural address-rule model
module tb_m_exc_unit;
  logic clk = 0, reset = 1;
  logic [31:0] instr = 0, mem_addr = 0, pc_i = 0;
  logic [4:0] exc_code_prev = 0;
  logic stall = 0, flush = 0, cnt_clr = 0;
  logic [4:0] em0, em1, ew0, ew1;
  logic we0, we1;
  logic [31:0] bv0, bv1;
  logic [7:0] ca0, cs0;
  logic [1:0] ca1, cs1;
  int n = 0, p = 0;
  logic [4:0] x_w[2];
  logic [31:0] x_bv[2];
  int x_ca[2], x_cs[2];

  localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LB = 6'b100000, SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;

  m_exc_unit dut0 (.clk(clk), .reset(reset), .instr(instr), .mem_addr(mem_addr), .pc_i(pc_i),
    .exc_code_prev(exc_code_prev), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .exc_code_m(em0), .mem_we_ok(we0), .exc_code_w(ew0), .bad_vaddr_w(bv0), .cnt_adel(ca0), .cnt_ades(cs0));

  m_exc_unit #(.NUM_DEV(3), .CNT_W(2)) dut1 (.clk(clk), .reset(reset), .instr(instr), .mem_addr(mem_addr), .pc_i(pc_i),
    .exc_code_prev(exc_code_prev), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .exc_code_m(em1), .mem_we_ok(we1), .exc_code_w(ew1), .bad_vaddr_w(bv1), .cnt_adel(ca1), .cnt_ades(cs1));

  always #5 clk = ~clk;

  function automatic int size_of(input logic [5:0] op);
    case (op)
      6'b100011, 6'b101011: return 4;
      6'b100001, 6'b100101, 6'b101001: return 2;
      6'b100000, 6'b100100, 6'b101000: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_store(input logic [31:0] ins);
    return size_of(ins[31:26]) != 0 && ins[31:29] == 3'b101;
  endfunction

  function automatic bit fault(input logic [31:0] ins, input logic [31:0] a, input int nd);
    int sz;
    bit dev, ro;
    longint aa, b;
    sz = size_of(ins[31:26]);
    dev = 0;
    ro = 0;
    aa = a;
    if (sz == 0) return 0;
    for (int k = 0; k < nd; k++) begin
      b = 64'h7f00 + 64'(k) * 16;
      if (aa >= b && aa < b + 12) dev = 1;
      if (aa == b + 8) ro = 1;
    end
    return (aa % sz != 0) || (aa > 64'h2fff && !dev) || (dev && sz != 4) || (is_store(ins) && ro);
  endfunction

  function automatic logic [4:0] code_m(input int nd);
    if (exc_code_prev != 0) return exc_code_prev;
    if (fault(instr, mem_addr, nd)) return is_store(instr) ? 5'd5 : 5'd4;
    return 5'd0;
  endfunction

  task automatic model_reset;
    for (int i = 0; i < 2; i++) begin
      x_w[i] = 0; x_bv[i] = 0; x_ca[i] = 0; x_cs[i] = 0;
    end
  endtask

  task automatic tick;
    int nd, mx;
    bit f;
    for (int i = 0; i < 2; i++) begin
      nd = i ? 3 : 2;
      mx = i ? 3 : 255;
      f = exc_code_prev == 0 && fault(instr, mem_addr, nd);
      if (cnt_clr) begin x_ca[i] = 0; x_cs[i] = 0; end
      if (flush) begin
        x_w[i] = 0; x_bv[i] = 0;
      end else if (!stall) begin
        x_w[i] = code_m(nd);
        x_bv[i] = exc_code_prev == 5'd4 ? pc_i : f ? mem_addr : 32'd0;
        if (f && is_store(instr)) x_cs[i] = x_cs[i] < mx ? x_cs[i] + 1 : mx;
        if (f && !is_store(instr)) x_ca[i] = x_ca[i] < mx ? x_ca[i] + 1 : mx;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1;
    model_reset();
    #1;
    n++; if (ew0 !== 5'd0) $display("FAIL rst_ew0 got %0d want 0", ew0); else p++;
    n++; if (bv0 !== 32'd0) $display("FAIL rst_bv0 got %h want 0", bv0); else p++;
    n++; if (ca0 !== 8'd0 || cs0 !== 8'd0) $display("FAIL rst_cnt0 got %0d/%0d want 0/0", ca0, cs0); else p++;
    n++; if (ew1 !== 5'd0 || bv1 !== 32'd0 || ca1 !== 2'd0 || cs1 !== 2'd0) $display("FAIL rst_dut1 got %0d %h %0d %0d want zeros", ew1, bv1, ca1, cs1); else p++;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_lw_misaligned;
    instr = {LW, 26'd0}; mem_addr = 32'h1002; exc_code_prev = 0;
    #1;
    n++; if (em0 !== 5'd4) $display("FAIL lw_code_m got %0d want 4", em0); else p++;
    n++; if (we0 !== 1'b0) $display("FAIL lw_we_ok got %b want 0", we0); else p++;
    tick();
    n++; if (ew0 !== 5'd4) $display("FAIL lw_code_w got %0d want 4", ew0); else p++;
    n++; if (bv0 !== 32'h1002) $display("FAIL lw_bvaddr got %h want 00001002", bv0); else p++;
    n++; if (ca0 !== 8'd1 || ca1 !== 2'd1) $display("FAIL lw_cnt_adel got %0d/%0d want 1/1", ca0, ca1); else p++;
  endtask

  task automatic test_device_store;
    instr = {SW, 26'd0}; mem_addr = 32'h7f18;
    #1;
    n++; if (em0 !== 5'd5 || we0 !== 1'b0) $display("FAIL sw_ro got %0d/%b want 5/0", em0, we0); else p++;
    n++; if (em1 !== 5'd5) $display("FAIL sw_ro_dut1 got %0d want 5", em1); else p++;
    mem_addr = 32'h7f14;
    #1;
    n++; if (em0 !== 5'd0 || we0 !== 1'b1) $display("FAIL sw_dev got %0d/%b want 0/1", em0, we0); else p++;
    instr = {SB, 26'd0}; mem_addr = 32'h7f04;
    #1;
    n++; if (em0 !== 5'd5 || we0 !== 1'b0) $display("FAIL sb_dev got %0d/%b want 5/0", em0, we0); else p++;
  endtask

  task automatic test_num_dev3;
    instr = {LW, 26'd0}; mem_addr = 32'h7f20;
    #1;
    n++; if (em1 !== 5'd0) $display("FAIL nd3_7f20 got %0d want 0", em1); else p++;
    n++; if (em0 !== 5'd4) $display("FAIL nd2_7f20 got %0d want 4", em0); else p++;
    mem_addr = 32'h7f2c;
    #1;
    n++; if (em1 !== 5'd4) $display("FAIL nd3_7f2c got %0d want 4", em1); else p++;
    mem_addr = 32'h3000;
    #1;
    n++; if (em1 !== 5'd4) $display("FAIL dm_3000 got %0d want 4", em1); else p++;
    mem_addr = 32'h2ffc;
    #1;
    n++; if (em1 !== 5'd0 || em0 !== 5'd0) $display("FAIL dm_2ffc got %0d/%0d want 0/0", em1, em0); else p++;
  endtask

  task automatic test_prev_masked;
    exc_code_prev = 5'd4; pc_i = 32'h3001; instr = {LH, 26'd0}; mem_addr = 32'h1;
    #1;
    n++; if (em0 !== 5'd4) $display("FAIL prev_code_m got %0d want 4", em0); else p++;
    tick();
    n++; if (ew0 !== 5'd4 || bv0 !== 32'h3001) $display("FAIL prev_w got %0d/%h want 4/00003001", ew0, bv0); else p++;
    n++; if (ca0 !== 8'd1) $display("FAIL prev_cnt got %0d want 1", ca0); else p++;
    exc_code_prev = 0;
  endtask

  task automatic test_stall_flush;
    instr = 0; mem_addr = 0;
    tick();
    instr = {SH, 26'd0}; mem_addr = 32'h3; stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n++; if (ew0 !== 5'd0 || cs0 !== 8'd0) $display("FAIL stall_%0d got %0d/%0d want 0/0", i, ew0, cs0); else p++;
    end
    flush = 1;
    tick();
    n++; if (ew0 !== 5'd0 || bv0 !== 32'd0 || cs0 !== 8'd0) $display("FAIL flush got %0d/%h/%0d want 0/0/0", ew0, bv0, cs0); else p++;
    flush = 0; stall = 0;
    tick();
    n++; if (ew0 !== 5'd5 || bv0 !== 32'h3) $display("FAIL sh_repeat got %0d/%h want 5/00000003", ew0, bv0); else p++;
    n++; if (cs0 !== 8'd1 || cs1 !== 2'd1) $display("FAIL sh_cnt got %0d/%0d want 1/1", cs0, cs1); else p++;
    instr = 0;
    tick();
    n++; if (cs0 !== 8'd1) $display("FAIL sh_once got %0d want 1", cs0); else p++;
  endtask

  task automatic test_saturation;
    instr = {LB, 26'd0}; mem_addr = 32'h5000;
    repeat (5) tick();
    n++; if (ca1 !== 2'd3) $display("FAIL sat got %0d want 3", ca1); else p++;
    n++; if (32'(ca0) !== x_ca[0]) $display("FAIL sat_dut0 got %0d want %0d", ca0, x_ca[0]); else p++;
    cnt_clr = 1; instr = {LW, 26'd0}; mem_addr = 32'h1002;
    tick();
    cnt_clr = 0;
    n++; if (ca1 !== 2'd1 || ca0 !== 8'd1) $display("FAIL clr_inc got %0d/%0d want 1/1", ca1, ca0); else p++;
    instr = 0;
    #2 reset = 1;
    #1;
    n++; if (ew0 !== 0 || bv0 !== 0 || ca0 !== 0 || cs0 !== 0) $display("FAIL async_rst0 got %0d %h %0d %0d want zeros", ew0, bv0, ca0, cs0); else p++;
    n++; if (ew1 !== 0 || bv1 !== 0 || ca1 !== 0 || cs1 !== 0) $display("FAIL async_rst1 got %0d %h %0d %0d want zeros", ew1, bv1, ca1, cs1); else p++;
    model_reset();
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_random;
    logic [5:0] ops[10] = '{6'b100011, 6'b100001, 6'b100101, 6'b100000, 6'b100100, 6'b101011, 6'b101001, 6'b101000, 6'b000000, 6'b001000};
    logic [4:0] e0, e1;
    for (int it = 0; it < 400; it++) begin
      instr = {ops[$urandom_range(0, 9)], 26'($urandom)};
      case ($urandom_range(0, 3))
        0: mem_addr = $urandom_range(0, 32'h3004);
        1: mem_addr = 32'h7f00 + $urandom_range(0, 63);
        2: mem_addr = $urandom;
        default: mem_addr = 32'h7f08 + 32'($urandom_range(0, 2)) * 16;
      endcase
      exc_code_prev = $urandom_range(0, 3) == 0 ? 5'($urandom_range(1, 12)) : 5'd0;
      pc_i = $urandom;
      stall = $urandom_range(0, 4) == 0;
      flush = $urandom_range(0, 6) == 0;
      cnt_clr = $urandom_range(0, 19) == 0;
      #1;
      e0 = code_m(2);
      e1 = code_m(3);
      n++; if (em0 !== e0) $display("FAIL rnd%0d_em0 got %0d want %0d", it, em0, e0); else p++;
      n++; if (em1 !== e1) $display("FAIL rnd%0d_em1 got %0d want %0d", it, em1, e1); else p++;
      n++; if (we0 !== (is_store(instr) && e0 == 0)) $display("FAIL rnd%0d_we0 got %b", it, we0); else p++;
      n++; if (we1 !== (is_store(instr) && e1 == 0)) $display("FAIL rnd%0d_we1 got %b", it, we1); else p++;
      tick();
      n++; if (ew0 !== x_w[0] || bv0 !== x_bv[0]) $display("FAIL rnd%0d_w0 got %0d/%h want %0d/%h", it, ew0, bv0, x_w[0], x_bv[0]); else p++;
      n++; if (ew1 !== x_w[1] || bv1 !== x_bv[1]) $display("FAIL rnd%0d_w1 got %0d/%h want %0d/%h", it, ew1, bv1, x_w[1], x_bv[1]); else p++;
      n++; if (32'(ca0) !== x_ca[0] || 32'(cs0) !== x_cs[0]) $display("FAIL rnd%0d_cnt0 got %0d/%0d want %0d/%0d", it, ca0, cs0, x_ca[0], x_cs[0]); else p++;
      n++; if (32'(ca1) !== x_ca[1] || 32'(cs1) !== x_cs[1]) $display("FAIL rnd%0d_cnt1 got %0d/%0d want %0d/%0d", it, ca1, cs1, x_ca[1], x_cs[1]); else p++;
    end
    stall = 0; flush = 0; cnt_clr = 0;
  endtask

  initial begin
    test_reset();
    test_lw_misaligned();
    test_device_store();
    test_num_dev3();
    test_prev_masked();
    test_stall_flush();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", p, n);
    $finish;
  end
endmodule
